// File: rtl/cw305_crypto_ctrl.sv
// cw305_crypto_ctrl: crypto-domain sequencer between register block and core.
// Skips key expansion for a repeated key, measures latency, aborts on timeout.
module cw305_crypto_ctrl #(
  parameter int pKEY_WIDTH = 128,
  parameter int pPT_WIDTH  = 128,
  parameter int pCT_WIDTH  = 128,
  parameter int pTIMEOUT   = 1024,
  parameter int pCNT_WIDTH = 32
) (
  input  logic                  crypto_clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [pKEY_WIDTH-1:0] key_i,
  input  logic [pPT_WIDTH-1:0]  text_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [pCT_WIDTH-1:0]  cipher_o,
  output logic [pPT_WIDTH-1:0]  textout_o,
  output logic [pCNT_WIDTH-1:0] cycles_o,
  output logic                  trig_o,
  output logic                  core_key_load_o,
  output logic [pKEY_WIDTH-1:0] core_key_o,
  input  logic                  core_key_ready_i,
  output logic                  core_load_o,
  output logic [pPT_WIDTH-1:0]  core_text_o,
  input  logic                  core_valid_i,
  input  logic [pCT_WIDTH-1:0]  core_result_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYLOAD,
    S_KEYWAIT,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam int TW = $clog2(pTIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(pTIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;

  state_t          state;
  logic            key_valid;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;

  assign ready_o = (state == S_IDLE);
  assign busy_o  = (state != S_IDLE);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      key_valid       <= 1'b0;
      tmo_cnt         <= '0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      cipher_o        <= '0;
      textout_o       <= '0;
      cycles_o        <= '0;
      trig_o          <= 1'b0;
      core_key_load_o <= 1'b0;
      core_key_o      <= '0;
      core_load_o     <= 1'b0;
      core_text_o     <= '0;
    end else begin
      core_key_load_o <= 1'b0;
      core_load_o     <= 1'b0;
      done_o          <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            core_key_o  <= key_i;
            core_text_o <= text_i;
            error_o     <= 1'b0;
            if (!key_valid || key_i != core_key_o) begin
              state           <= S_KEYLOAD;
              core_key_load_o <= 1'b1;
            end else begin
              state       <= S_LOAD;
              core_load_o <= 1'b1;
              trig_o      <= 1'b1;
            end
          end
        end
        S_KEYLOAD: begin
          state   <= S_KEYWAIT;
          tmo_cnt <= '0;
        end
        S_KEYWAIT: begin
          if (core_key_ready_i) begin
            key_valid   <= 1'b1;
            state       <= S_LOAD;
            core_load_o <= 1'b1;
            trig_o      <= 1'b1;
          end else if (tmo_hit) begin
            error_o   <= 1'b1;
            key_valid <= 1'b0;
            state     <= S_DONE;
            done_o    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        S_LOAD: begin
          state    <= S_RUN;
          cycles_o <= CNT_ONE;
          tmo_cnt  <= '0;
        end
        S_RUN: begin
          if (cycles_o != CNT_MAX) begin
            cycles_o <= cycles_o + CNT_ONE;
          end
          // a valid on the final allowed cycle beats the timeout
          if (core_valid_i) begin
            cipher_o  <= core_result_i;
            textout_o <= core_text_o;
            trig_o    <= 1'b0;
            state     <= S_DONE;
            done_o    <= 1'b1;
          end else if (tmo_hit) begin
            error_o   <= 1'b1;
            key_valid <= 1'b0;
            trig_o    <= 1'b0;
            state     <= S_DONE;
            done_o    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cw305_crypto_ctrl.sv
// tb_cw305_crypto_ctrl: schedule-based reference model with per-cycle compare.
// Each operation's timeline is derived up front from the core response delays.
module tb_cw305_crypto_ctrl;
  localparam int KW   = 128;
  localparam int PW   = 128;
  localparam int CTW  = 128;
  localparam int TMO  = 40;
  localparam int CNTW = 5;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            crypto_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start_i = 1'b0;
  logic [KW-1:0]   key_i = '0;
  logic [PW-1:0]   text_i = '0;
  logic            ready_o, busy_o, done_o, error_o, trig_o;
  logic [CTW-1:0]  cipher_o;
  logic [PW-1:0]   textout_o;
  logic [CNTW-1:0] cycles_o;
  logic            core_key_load_o, core_load_o;
  logic [KW-1:0]   core_key_o;
  logic [PW-1:0]   core_text_o;
  logic            core_key_ready_i = 1'b0;
  logic            core_valid_i = 1'b0;
  logic [CTW-1:0]  core_result_i = '0;

  always #5 crypto_clk = ~crypto_clk;

  cw305_crypto_ctrl #(
    .pKEY_WIDTH(KW), .pPT_WIDTH(PW), .pCT_WIDTH(CTW),
    .pTIMEOUT(TMO), .pCNT_WIDTH(CNTW)
  ) dut (
    .crypto_clk(crypto_clk), .reset_n(reset_n),
    .start_i(start_i), .key_i(key_i), .text_i(text_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .cipher_o(cipher_o), .textout_o(textout_o),
    .cycles_o(cycles_o), .trig_o(trig_o),
    .core_key_load_o(core_key_load_o), .core_key_o(core_key_o),
    .core_key_ready_i(core_key_ready_i),
    .core_load_o(core_load_o), .core_text_o(core_text_o),
    .core_valid_i(core_valid_i), .core_result_i(core_result_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge crypto_clk) cyc <= cyc + 1;

  // model of the current/last operation: periods are edge counts
  bit act, reload, has_load, kv;
  int s_p, l_p, d_p, kr_p = -1, v_p = -1;
  logic [127:0] n_key, n_text, n_cip, n_tout, res_val;
  logic [127:0] o_key, o_ctext, o_cip, o_tout;
  bit n_err, o_err;
  int n_cyc, o_cyc;

  int kl_cnt = 0, ld_cnt = 0, done_cnt = 0;
  int last_done_p = -1, last_ld_p = -1;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, cyc, a, e);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    act = 0; kv = 0; reload = 0; has_load = 0;
    kr_p = -1; v_p = -1; s_p = 0; l_p = 0; d_p = 0;
    n_key = '0; n_text = '0; n_cip = '0; n_tout = '0;
    o_key = '0; o_ctext = '0; o_cip = '0; o_tout = '0;
    n_err = 0; o_err = 0; n_cyc = 0; o_cyc = 0;
  endtask

  task automatic step();
    @(posedge crypto_clk);
    #1;
  endtask

  task automatic wait_until(input int p);
    while (cyc < p) step();
  endtask

  task automatic launch(input logic [127:0] key, text, res,
                        input int kd, vd);
    if (act) begin
      o_key = n_key; o_ctext = n_text; o_cip = n_cip;
      o_tout = n_tout; o_err = n_err; o_cyc = n_cyc;
    end
    s_p = cyc + 1;
    reload = !kv || (key != o_key);
    n_key = key; n_text = text; res_val = res;
    kr_p = -1; v_p = -1; has_load = 1; l_p = s_p;
    if (reload) begin
      if (kd >= 1 && kd <= TMO) begin
        kr_p = s_p + kd; l_p = s_p + kd + 1; kv = 1;
      end else begin
        kr_p = (kd == 0) ? s_p : -1;
        has_load = 0; d_p = s_p + TMO + 1;
      end
    end
    if (has_load) begin
      if (vd >= 1 && vd <= TMO) begin
        v_p = l_p + vd; d_p = v_p + 1;
        n_cip = res; n_tout = text; n_err = 0; n_cyc = sat(vd + 1);
      end else begin
        v_p = (vd == TMO + 1) ? l_p + vd : -1;
        d_p = l_p + TMO + 1;
        n_cip = o_cip; n_tout = o_tout; n_err = 1;
        n_cyc = sat(TMO + 1); kv = 0;
      end
    end else begin
      n_cip = o_cip; n_tout = o_tout; n_err = 1; n_cyc = o_cyc; kv = 0;
    end
    act = 1;
    start_i = 1; key_i = key; text_i = text;
    step();
    start_i = 0; key_i = rnd128(); text_i = rnd128();
  endtask

  task automatic poke(input int q);
    wait_until(q);
    start_i = 1; key_i = rnd128(); text_i = rnd128();
    step();
    start_i = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    start_i = 0;
    step();
    step();
    reset_n = 1;
  endtask

  always @(posedge crypto_clk) begin
    #1;
    core_key_ready_i = (cyc == kr_p);
    core_valid_i = (cyc == v_p);
    core_result_i = core_valid_i ? res_val : rnd128();
  end

  int  p;
  bit  pre, post, e_busy, e_err;
  always @(negedge crypto_clk) begin
    p = cyc;
    pre = !act || p < s_p;
    post = act && p >= d_p;
    e_busy = act && p >= s_p && p <= d_p;
    e_err = post ? n_err : (pre ? o_err : 1'b0);
    chk("ready", 128'(ready_o), 128'(!e_busy));
    chk("busy", 128'(busy_o), 128'(e_busy));
    chk("key_load", 128'(core_key_load_o),
        128'(act && reload && p == s_p));
    chk("load", 128'(core_load_o), 128'(act && has_load && p == l_p));
    chk("trig", 128'(trig_o),
        128'(act && has_load && p >= l_p && p < d_p));
    chk("done", 128'(done_o), 128'(act && p == d_p));
    chk("error", 128'(error_o), 128'(e_err));
    chk("cipher", cipher_o, post ? n_cip : o_cip);
    chk("textout", textout_o, post ? n_tout : o_tout);
    chk("core_key", core_key_o, pre ? o_key : n_key);
    chk("core_text", core_text_o, pre ? o_ctext : n_text);
    if (post) chk("cycles", 128'(cycles_o), 128'(n_cyc));
    else if (pre) chk("cycles", 128'(cycles_o), 128'(o_cyc));
    if (core_key_load_o) kl_cnt++;
    if (core_load_o) begin ld_cnt++; last_ld_p = p; end
    if (done_o) begin done_cnt++; last_done_p = p; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [127:0] k1, k2, keys [3];
  int kl0, ld0, dn0, dp1, r, kd, vd;

  initial begin
    model_reset();
    step();
    chk("rst_ready", 128'(ready_o), 128'd1);
    chk("rst_cycles", 128'(cycles_o), 128'd0);
    step();
    reset_n = 1;
    step();
    k1 = rnd128();
    k2 = ~k1;

    // new key: ready 10 after key load, valid 11 after load
    kl0 = kl_cnt; ld0 = ld_cnt; dn0 = done_cnt;
    launch(k1, 128'h1111, 128'hC1C1, 10, 11);
    wait_until(d_p + 1);
    chk("t1_cycles", 128'(cycles_o), 128'd12);
    chk("t1_cipher", cipher_o, 128'hC1C1);
    chk("t1_err", 128'(error_o), 128'd0);
    chk("t1_keyloads", 128'(kl_cnt - kl0), 128'd1);
    chk("t1_dones", 128'(done_cnt - dn0), 128'd1);
    chk("t1_latency", 128'(last_done_p - s_p), 128'd23);

    // same key: no expansion, load in the first cycle
    kl0 = kl_cnt;
    launch(k1, 128'h2222, 128'hC2C2, 0, 1);
    wait_until(d_p + 1);
    chk("t2_keyloads", 128'(kl_cnt - kl0), 128'd0);
    chk("t2_load_lat", 128'(last_ld_p - s_p), 128'd0);
    chk("t2_textout", textout_o, 128'h2222);
    chk("t2_cycles", 128'(cycles_o), 128'd2);
    dp1 = last_done_p;
    launch(k1, 128'h3333, 128'hC3C3, 0, 1);
    wait_until(d_p + 1);
    chk("b2b_period", 128'(last_done_p - dp1), 128'd4);

    // new key then RUN timeout, with ignored starts in RUN and DONE
    kl0 = kl_cnt; ld0 = ld_cnt; dn0 = done_cnt;
    launch(k2, 128'h4444, 128'hC4C4, 5, TMO + 5);
    poke(l_p + 3);
    poke(d_p);
    wait_until(d_p + 1);
    chk("t3_err", 128'(error_o), 128'd1);
    chk("t3_cipher", cipher_o, 128'hC3C3);
    chk("t3_cycles", 128'(cycles_o), 128'd31);
    chk("t3_loads", 128'(ld_cnt - ld0), 128'd1);
    chk("t3_dones", 128'(done_cnt - dn0), 128'd1);
    chk("t3_keyloads", 128'(kl_cnt - kl0), 128'd1);
    kl0 = kl_cnt;
    launch(k2, 128'h5555, 128'hC5C5, 2, 3);
    wait_until(d_p + 1);
    chk("t4_keyloads", 128'(kl_cnt - kl0), 128'd1);
    chk("t4_cipher", cipher_o, 128'hC5C5);

    // late valid saturates the latency counter
    launch(k2, 128'h6666, 128'hC6C6, 0, 35);
    wait_until(d_p + 1);
    chk("sat_cycles", 128'(cycles_o), 128'd31);
    chk("sat_err", 128'(error_o), 128'd0);

    // reset mid-RUN drops the key
    launch(k2, 128'h7777, 128'hC7C7, 0, 30);
    wait_until(l_p + 5);
    do_reset();
    chk("mr_ready", 128'(ready_o), 128'd1);
    chk("mr_cipher", cipher_o, 128'd0);
    chk("mr_cycles", 128'(cycles_o), 128'd0);
    step();
    kl0 = kl_cnt;
    launch(k2, 128'h8888, 128'hC8C8, 3, 4);
    wait_until(d_p + 1);
    chk("mr_keyloads", 128'(kl_cnt - kl0), 128'd1);

    keys[0] = k1; keys[1] = k2; keys[2] = rnd128();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      kd = (r == 0) ? 0 : (r == 1) ? TMO + 2 : $urandom_range(1, 12);
      r = $urandom_range(0, 19);
      vd = (r == 0) ? TMO + 1 : (r == 1) ? TMO :
           (r == 2) ? $urandom_range(31, 39) : $urandom_range(1, 8);
      launch(keys[$urandom_range(0, 2)], rnd128(), rnd128(), kd, vd);
      if ($urandom_range(0, 3) == 0)
        poke(s_p + $urandom_range(0, d_p - s_p));
      if ($urandom_range(0, 14) == 0) begin
        wait_until(s_p + $urandom_range(0, d_p - s_p));
        do_reset();
      end else begin
        wait_until(d_p + 1 + $urandom_range(0, 3));
      end
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cw305_crypto_ctrl.md
# cw305_crypto_ctrl

Crypto-domain sequencer between the register block and the crypto core. Accepts the one-cycle start pulse with key and plaintext from the register block, performs key expansion only when the key has changed, runs one encryption, and returns the ready, busy and done handshake plus results. It also drives the scope trigger, measures core latency, and aborts on a core timeout.

## Interface
- pKEY_WIDTH, 128: key width.
- pPT_WIDTH, 128: plaintext width.
- pCT_WIDTH, 128: ciphertext width.
- pTIMEOUT, 1024: maximum cycles spent waiting in KEYWAIT or RUN; must be ≥ 2.
- pCNT_WIDTH, 32: latency counter width.

Ports:
- crypto_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start_i  in  1  one-cycle start pulse from the register block.
- key_i  in  pKEY_WIDTH  key, sampled on the accepted start.
- text_i  in  pPT_WIDTH  plaintext, sampled on the accepted start.
- ready_o  out  1  high in IDLE; drives the register block's ready input.
- busy_o  out  1  high in every non-IDLE state.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  timeout status, valid from done_o, held until the next accepted start.
- cipher_o  out  pCT_WIDTH  last core result.
- textout_o  out  pPT_WIDTH  plaintext of the last completed operation.
- cycles_o  out  pCNT_WIDTH  trigger-high cycle count of the last operation.
- trig_o  out  1  scope trigger.
- core_key_load_o  out  1  one-cycle key-expansion request.
- core_key_o  out  pKEY_WIDTH  key to the core, held stable.
- core_key_ready_i  in  1  key expansion complete (level or pulse).
- core_load_o  out  1  one-cycle encrypt request.
- core_text_o  out  pPT_WIDTH  plaintext to the core, held stable.
- core_valid_i  in  1  result valid.
- core_result_i  in  pCT_WIDTH  result, sampled when core_valid_i is high.

## Operation
- States: IDLE, KEYLOAD, KEYWAIT, LOAD, RUN, DONE.
- IDLE behaviour:
  - start_i is accepted only in IDLE. An accepted start captures key_i into core_key_o and text_i into core_text_o, and clears error_o.
  - The next state is KEYLOAD if key_valid=0 or key_i differs from core_key_o. Otherwise the next state is LOAD.
- KEYLOAD: core_key_load_o=1 for exactly one cycle, then KEYWAIT.
- KEYWAIT: on core_key_ready_i=1, set key_valid and go to LOAD. core_key_ready_i is ignored during the KEYLOAD cycle.
- LOAD:
  - core_load_o=1 for exactly one cycle and trig_o rises in the same cycle.
  - cycles_o is cleared to 1 here, then goes to RUN.
- RUN:
  - cycles_o increments every cycle, saturating at all-ones.
  - On core_valid_i=1, capture core_result_i into cipher_o and core_text_o into textout_o, then go to DONE. trig_o falls on that transition.
- Timeout:
  - A per-state cycle counter runs in KEYWAIT and RUN.
  - On reaching pTIMEOUT without the awaited input, set error_o=1, clear key_valid and trig_o, and go to DONE.
  - cipher_o and textout_o keep their previous values on timeout.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i in any non-IDLE state, including DONE, is ignored with no side effects.
- Mid-operation reset: every register returns to its reset value, key_valid=0, and the next start performs key expansion.

## Timing
- Reset values:
  - ready_o=1.
  - All other outputs are 0: busy_o, done_o, error_o, trig_o, cipher_o, textout_o, cycles_o, core_key_load_o, core_load_o, core_key_o, core_text_o.
  - key_valid=0, state=IDLE.
- All outputs are registered except ready_o and busy_o, which are decoded from the state register.
- With start sampled at edge 0:
  - busy_o is high from cycle 1.
  - For a known key, core_load_o and trig_o are high in cycle 1.
  - For a new key, core_key_load_o is high in cycle 1. core_load_o follows in the cycle after the edge that samples core_key_ready_i.
- For core_valid_i sampled at edge N:
  - cipher_o is updated and trig_o is low from cycle N+1.
  - done_o is high in cycle N+1.
  - ready_o is high from cycle N+2.
- cycles_o = number of cycles trig_o was high, counting the LOAD cycle plus RUN cycles up to and including the valid cycle.
- Simultaneous core_valid_i and timeout expiry: valid wins, and error_o stays 0.
- Minimum back-to-back period with no key change and a core valid in its first RUN cycle: start to start is 4 cycles.

## Test plan
- Reset, then start with key K1, text P1. Core ready 10 cycles after key load, valid 11 cycles after load → one core_key_load_o pulse; cipher_o = result; cycles_o=12; one done_o pulse; error_o=0.
- Repeat start with key K1, text P2 → no core_key_load_o; core_load_o in the cycle after start; textout_o=P2.
- Start with key K2 → key reload occurs. Then hold core_valid_i low → done_o after 1024 RUN cycles with error_o=1 and cipher_o unchanged. Next start with K2 → key reloads again.
- Pulse start_i during RUN and during DONE → ignored; exactly one done_o; core_load_o count stays 1.
- Assert reset_n low mid-RUN, then release → all outputs at reset values; next start with the unchanged key triggers core_key_load_o.
- Core valid held 2^32+5 cycles late with pTIMEOUT enlarged → cycles_o saturates at 0xFFFFFFFF.
